// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and filters the raw pins, frames bytes and turns
// E0/F0/E1 prefix sequences into toggle-style ps2_key events. Define PS2_PARITY_CHECK_EN to reject bad-parity frames.
module ps2_key_decoder #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 40000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic [10:0] ps2_key,
   output logic        frame_err,
   output logic        busy
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   // The cycle carrying fall counts as the first idle cycle, so the error lands exactly TIMEOUT cycles after it.
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } bit_state_t;

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_s;
   logic          data_s;
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   bit_state_t    state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shift_q, shift_n;
   logic          par_q, par_n;
   logic [TW-1:0] tmo_cnt, tmo_n;
   logic          frame_ok;
   logic          byte_valid;
   logic          frame_bad;

   logic          ext;
   logic          rel;
   logic [2:0]    swallow;

   // NOTE: the synchronisers and filtered clock reset to the idle bus level (high) so
   // leaving reset never looks like a falling edge.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
      end
   end

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];

   // NOTE: every sequential block uses non-blocking assignments so all registers
   // update from the same pre-edge values.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
      end else if (clk_s == filt_clk) begin
         filt_cnt <= '0;
         fall     <= 1'b0;
      end else if (filt_cnt == FILT_LAST) begin
         filt_clk <= clk_s;
         filt_cnt <= '0;
         fall     <= ~clk_s;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
         fall     <= 1'b0;
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = data_s & (^{shift_q, par_q});
`else
   logic unused_parity;
   assign frame_ok      = data_s;
   assign unused_parity = par_q;
`endif

   // NOTE: every variable gets a default at the top of the block, so no path
   // through the case statement can infer a latch.
   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      shift_n    = shift_q;
      par_n      = par_q;
      tmo_n      = tmo_cnt;
      byte_valid = 1'b0;
      frame_bad  = 1'b0;

      case (state)
         S_IDLE: begin
            if (fall && !data_s) begin
               state_n   = S_DATA;
               bit_cnt_n = '0;
            end
         end
         S_DATA: begin
            if (fall) begin
               shift_n[bit_cnt] = data_s;
               if (bit_cnt == 3'd7) state_n = S_PARITY;
               else                 bit_cnt_n = bit_cnt + 1'b1;
            end
         end
         S_PARITY: begin
            if (fall) begin
               par_n   = data_s;
               state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (fall) begin
               state_n = S_IDLE;
               if (frame_ok) byte_valid = 1'b1;
               else          frame_bad  = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // A fall in the same cycle always beats the timeout.
      if (state == S_IDLE || fall) begin
         tmo_n = '0;
      end else if (tmo_cnt == TMO_LAST) begin
         tmo_n     = '0;
         state_n   = S_IDLE;
         frame_bad = 1'b1;
      end else begin
         tmo_n = tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         shift_q <= shift_n;
         par_q   <= par_n;
         tmo_cnt <= tmo_n;
      end
   end

   assign busy = (state != S_IDLE);

   // Byte decoder: acts on the stop-bit edge, using the complete byte already in shift_q.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         ps2_key   <= '0;
         frame_err <= 1'b0;
         ext       <= 1'b0;
         rel       <= 1'b0;
         swallow   <= '0;
      end else begin
         frame_err <= frame_bad;
         if (frame_bad) begin
            ext     <= 1'b0;
            rel     <= 1'b0;
            swallow <= '0;
         end else if (byte_valid) begin
            if (swallow != 3'd0) begin
               swallow <= swallow - 1'b1;
               ext     <= 1'b0;
               rel     <= 1'b0;
            end else begin
               case (shift_q)
                  8'hE0: ext <= 1'b1;
                  8'hF0: rel <= 1'b1;
                  8'hE1: begin
                     swallow <= 3'd7;
                     ext     <= 1'b0;
                     rel     <= 1'b0;
                  end
                  8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                     ext <= 1'b0;
                     rel <= 1'b0;
                  end
                  default: begin
                     ps2_key <= {~ps2_key[10], ~rel, ext, shift_q};
                     ext     <= 1'b0;
                     rel     <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: vector table, timeout/reset/glitch/Pause sequences
// and randomized frames checked against a byte-level reference model.
module tb_ps2_key_decoder;

   localparam int FILTER_LEN = 4;
   localparam int TIMEOUT    = 300;
   localparam int HALF       = 16;
   localparam int SETUP      = 8;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ps2_clk_in;
   logic        ps2_data_in;
   logic [10:0] ps2_key;
   logic        frame_err;
   logic        busy;

   int n_checks    = 0;
   int n_pass      = 0;
   int cyc         = 0;
   int err_pulses  = 0;
   int last_low_cyc = 0;

   bit          m_ext, m_rel;
   int          m_swallow;
   logic [10:0] m_key;

   typedef struct {
      logic [7:0]  data;
      bit          par_bad;
      bit          stop;
      logic [10:0] exp_key;
      int          exp_err;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [NV];

   ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_key    (ps2_key),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;
   always @(negedge clk_sys) if (!reset && frame_err) err_pulses <= err_pulses + 1;

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   function automatic void model_reset();
      m_ext = 1'b0; m_rel = 1'b0; m_swallow = 0; m_key = '0;
   endfunction

   // Byte-level behaviour of the decoder; returns the expected number of frame_err pulses.
   function automatic int model_frame(input logic [7:0] d, input bit good);
      if (!good) begin
         m_ext = 1'b0; m_rel = 1'b0; m_swallow = 0;
         return 1;
      end
      if (m_swallow > 0) begin
         m_swallow--; m_ext = 1'b0; m_rel = 1'b0;
      end else if (d == 8'hE0) m_ext = 1'b1;
      else if (d == 8'hF0) m_rel = 1'b1;
      else if (d == 8'hE1) begin
         m_swallow = 7; m_ext = 1'b0; m_rel = 1'b0;
      end else if (d inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
         m_ext = 1'b0; m_rel = 1'b0;
      end else begin
         m_key = {~m_key[10], ~m_rel, m_ext, d};
         m_ext = 1'b0; m_rel = 1'b0;
      end
      return 0;
   endfunction

   task automatic ps2_bit(input bit b);
      ps2_data_in = b;
      repeat (SETUP) @(negedge clk_sys);
      ps2_clk_in   = 1'b0;
      last_low_cyc = cyc;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
      repeat (SETUP) @(negedge clk_sys);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bit,
                             input int nbits);
      logic [10:0] bits;
      bits = {stop_bit, (~^d) ^ par_bad, d, 1'b0};
      for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
      ps2_data_in = 1'b1;
      repeat (4) @(negedge clk_sys);
   endtask

   task automatic frame_and_check(input string name, input logic [7:0] d, input bit par_bad,
                                  input bit stop_bit, input logic [10:0] exp_key,
                                  input int exp_err);
      int e0;
      e0 = err_pulses;
      send_frame(d, par_bad, stop_bit, 11);
      check({name, " key"}, int'(ps2_key), int'(exp_key));
      check({name, " frame_err pulses"}, err_pulses - e0, exp_err);
   endtask

   task automatic model_frame_check(input string name, input logic [7:0] d, input bit par_bad,
                                    input bit stop_bit);
      int exp_err;
      exp_err = model_frame(d, stop_bit && !(PAR_CHK && par_bad));
      frame_and_check(name, d, par_bad, stop_bit, m_key, exp_err);
   endtask

   initial begin
      int          e0, waited, busy_seen;
      logic [10:0] key_before, exp_key;
      logic [7:0]  pause_seq [8];
      logic [7:0]  specials [6];
      logic [7:0]  d;
      bit          pb, sb;

      tbl[0]  = '{8'h1C, 1'b0, 1'b1, 11'h61C, 0};
      tbl[1]  = '{8'hF0, 1'b0, 1'b1, 11'h61C, 0};
      tbl[2]  = '{8'h1C, 1'b0, 1'b1, 11'h01C, 0};
      tbl[3]  = '{8'hE0, 1'b0, 1'b1, 11'h01C, 0};
      tbl[4]  = '{8'h75, 1'b0, 1'b1, 11'h775, 0};
      tbl[5]  = '{8'hE0, 1'b0, 1'b1, 11'h775, 0};
      tbl[6]  = '{8'hF0, 1'b0, 1'b1, 11'h775, 0};
      tbl[7]  = '{8'h75, 1'b0, 1'b1, 11'h175, 0};
      tbl[8]  = '{8'h1C, 1'b1, 1'b1, PAR_CHK ? 11'h175 : 11'h61C, PAR_CHK ? 1 : 0};
      tbl[9]  = '{8'h1C, 1'b0, 1'b0, tbl[8].exp_key, 1};
      tbl[10] = '{8'hE0, 1'b0, 1'b1, tbl[8].exp_key, 0};
      tbl[11] = '{8'hF0, 1'b0, 1'b0, tbl[8].exp_key, 1};
      tbl[12] = '{8'h1C, 1'b0, 1'b1, PAR_CHK ? 11'h61C : 11'h21C, 0};
      tbl[13] = '{8'hAA, 1'b0, 1'b1, tbl[12].exp_key, 0};
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      specials  = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

      reset       = 1'b1;
      ps2_clk_in  = 1'b1;
      ps2_data_in = 1'b1;
      repeat (5) @(negedge clk_sys);
      check("reset ps2_key", int'(ps2_key), 0);
      check("reset frame_err", int'(frame_err), 0);
      check("reset busy", int'(busy), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk_sys);

      for (int i = 0; i < NV; i++)
         frame_and_check($sformatf("vec%0d", i), tbl[i].data, tbl[i].par_bad, tbl[i].stop,
                         tbl[i].exp_key, tbl[i].exp_err);

      // Timeout: start bit plus four data bits, then the clock stops.
      e0 = err_pulses;
      send_frame(8'h1C, 1'b0, 1'b1, 5);
      check("timeout busy mid-frame", int'(busy), 1);
      waited = 0;
      while (!frame_err && waited < 2 * TIMEOUT) begin
         @(negedge clk_sys);
         waited++;
      end
      if (!frame_err) check("timeout frame_err reached", 0, 1);
      else check("timeout latency", cyc - last_low_cyc, 2 + FILTER_LEN + TIMEOUT);
      @(negedge clk_sys);
      check("timeout pulse width", int'(frame_err), 0);
      check("timeout busy dropped", int'(busy), 0);
      exp_key = {~tbl[NV-1].exp_key[10], 1'b1, 1'b0, 8'h1C};
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("post-timeout key", int'(ps2_key), int'(exp_key));
      check("post-timeout frame_err pulses", err_pulses - e0, 1);

      // Reset in the middle of a frame drops the partial byte.
      send_frame(8'h55, 1'b0, 1'b1, 4);
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("mid-frame reset key", int'(ps2_key), 0);
      check("mid-frame reset busy", int'(busy), 0);
      reset = 1'b0;
      model_reset();
      repeat (5) @(negedge clk_sys);
      model_frame_check("after reset 1C", 8'h1C, 1'b0, 1'b1);

      // Short low glitch with data low: a filtered fall would start a frame.
      ps2_data_in = 1'b0;
      ps2_clk_in  = 1'b0;
      repeat (FILTER_LEN - 1) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
      busy_seen  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_sys);
         if (busy) busy_seen = 1;
      end
      ps2_data_in = 1'b1;
      check("glitch busy", busy_seen, 0);

      key_before = ps2_key;
      for (int i = 0; i < 8; i++)
         model_frame_check($sformatf("pause%0d", i), pause_seq[i], 1'b0, 1'b1);
      check("pause key unchanged", int'(ps2_key), int'(key_before));

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 9))
            0:       d = 8'hE0;
            1, 2:    d = 8'hF0;
            3:       d = specials[$urandom_range(0, 5)];
            4:       d = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'(i);
            default: d = 8'($urandom_range(0, 255));
         endcase
         pb = ($urandom_range(0, 9) == 0);
         sb = ($urandom_range(0, 9) != 0);
         model_frame_check($sformatf("rand%0d", i), d, pb, sb);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
